// File: rtl/regfile_sb_pkg.sv
// Core-wide constants shared by the register file, its scoreboard and the bench.
package regfile_sb_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned DEF_NUM_RD = 3;
  localparam int unsigned DEF_CNT_W  = 2;
  localparam int unsigned DEF_RO_IDX = 7;
  // The highest-numbered read port is reserved for the debugger.
  localparam int unsigned DBG_PORT   = DEF_NUM_RD - 1;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/execute side bus of the register file: read ports, issue check and writeback.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NUM_RD = 3
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_chk;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_valid;
  logic                     iss_wr;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_stall;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     sb_err;

  modport master (
    output rd_addr, rd_chk, iss_valid, iss_wr, iss_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_busy, iss_stall, sb_err
  );

  modport slave (
    input  rd_addr, rd_chk, iss_valid, iss_wr, iss_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_busy, iss_stall, sb_err
  );
endinterface

// File: rtl/sb_counter.sv
// Pending-write counter for one register: net count after this cycle's writeback.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] eff,
  output logic             full,
  output logic             underflow
);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A writeback against an empty counter is flagged instead of wrapping.
  always_comb begin
    underflow = dec && (cnt_q == '0);
    eff       = cnt_q - CNT_W'(dec && (cnt_q != '0));
    full      = (eff == CNT_W'(CNT_MAX));
    cnt_d     = eff + CNT_W'(inc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with same-cycle writeback bypass and a
// per-register pending-write scoreboard that drives the decode stall.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter bit          RO_EN  = 1'b1,
  parameter int unsigned RO_IDX = DEF_RO_IDX
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic                     err_q, err_d;
  logic                     wp, acc, full_c, stall_c;
  logic [ADDR_W-1:0]        ra;
  logic [DEPTH-1:0]         dec_v, inc_v, full_v, unf_v;
  logic [CNT_W-1:0]         eff_a [DEPTH];
  logic [NUM_RD-1:0]        rd_busy_c;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;

  for (genvar r = 0; r < DEPTH; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_v[r]),
      .dec       (dec_v[r]),
      .eff       (eff_a[r]),
      .full      (full_v[r]),
      .underflow (unf_v[r])
    );
  end

  // Writeback qualification and bypassed reads; busy uses the post-writeback count.
  always_comb begin
    wp        = bus.wr_en && !(RO_EN && (bus.wr_addr == ADDR_W'(RO_IDX)));
    dec_v     = '0;
    dec_v[bus.wr_addr] = wp;
    ra        = '0;
    rd_busy_c = '0;
    rd_data_c = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rd_data_c[i*DATA_W +: DATA_W] = (wp && (bus.wr_addr == ra)) ? bus.wr_data : mem_q[ra];
      rd_busy_c[i] = (eff_a[ra] != '0);
    end
  end

  // Issue check: source hazards on checked ports, or destination counter saturated.
  always_comb begin
    full_c  = bus.iss_wr && full_v[bus.iss_addr];
    stall_c = bus.iss_valid && ((|(bus.rd_chk & rd_busy_c)) || full_c);
    acc     = bus.iss_valid && !stall_c && bus.iss_wr &&
              !(RO_EN && (bus.iss_addr == ADDR_W'(RO_IDX)));
    inc_v   = '0;
    inc_v[bus.iss_addr] = acc;
  end

  always_comb begin
    mem_d = mem_q;
    if (wp) mem_d[bus.wr_addr] = bus.wr_data;
    err_d = err_q || (|(unf_v & dec_v));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      err_q <= err_d;
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.rd_busy   = rd_busy_c;
  assign bus.iss_stall = stall_c;
  assign bus.sb_err    = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected values queued per step, popped and asserted.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int unsigned DW = DEF_DATA_W;
  localparam int unsigned AW = DEF_ADDR_W;
  localparam int unsigned NR = DEF_NUM_RD;
  localparam int unsigned CW = DEF_CNT_W;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_sb #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW),
    .RO_EN(1'b1), .RO_IDX(DEF_RO_IDX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] rdata(input int p);
    return 32'(bus.rd_data[p*DW +: DW]);
  endfunction

  function automatic logic [31:0] rbusy(input int p);
    return 32'(bus.rd_busy[p]);
  endfunction

  task automatic idle();
    bus.rd_addr   = '0;
    bus.rd_chk    = '0;
    bus.iss_valid = 1'b0;
    bus.iss_wr    = 1'b0;
    bus.iss_addr  = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
  endtask

  task automatic set_rd(input int p, input int a, input logic c);
    bus.rd_addr[p*AW +: AW] = AW'(a);
    bus.rd_chk[p]           = c;
  endtask

  task automatic issue(input logic wr, input int a);
    bus.iss_valid = 1'b1;
    bus.iss_wr    = wr;
    bus.iss_addr  = AW'(a);
  endtask

  task automatic wback(input int a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sbq.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h required <queued value>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] v);
    push(t, v);
    pop_chk(obs);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);

    // reset hold: every address reads zero and nothing is pending
    for (int a = 0; a < 8; a++) begin
      set_rd(0, a, 1'b1);
      set_rd(DBG_PORT, a, 1'b0);
      push("rst_data0", 32'h0);
      push("rst_busy0", 32'h0);
      push("rst_dbg",   32'h0);
      #1;
      pop_chk(rdata(0));
      pop_chk(rbusy(0));
      pop_chk(rdata(DBG_PORT));
      @(negedge clk);
    end
    issue(1'b1, 3);
    #1;
    chk("rst_stall", 32'(bus.iss_stall), 32'h0);
    chk("rst_err",   32'(bus.sb_err),    32'h0);
    @(negedge clk);
    set_rd(0, 3, 1'b1);
    #1;
    chk("rst_busy_r3", rbusy(0), 32'h0);
    chk("rst_stall2",  32'(bus.iss_stall), 32'h0);
    idle();
    reset = 1'b0;

    // RAW hazard on r3 resolved by a same-cycle writeback
    @(negedge clk); idle(); issue(1'b1, 3);
    #1; chk("iss_r3", 32'(bus.iss_stall), 32'h0);
    @(negedge clk); idle(); issue(1'b0, 0); set_rd(0, 3, 1'b1);
    #1;
    chk("raw_busy",  rbusy(0), 32'h1);
    chk("raw_stall", 32'(bus.iss_stall), 32'h1);
    @(negedge clk);
    #1; chk("raw_stall_hold", 32'(bus.iss_stall), 32'h1);
    @(negedge clk); wback(3, 16'h1234);
    #1;
    chk("byp_data",  rdata(0), 32'h1234);
    chk("byp_busy",  rbusy(0), 32'h0);
    chk("byp_stall", 32'(bus.iss_stall), 32'h0);
    @(negedge clk); idle(); set_rd(1, 3, 1'b1);
    #1;
    chk("arr_r3",   rdata(1), 32'h1234);
    chk("arr_busy", rbusy(1), 32'h0);
    chk("err_ok1",  32'(bus.sb_err), 32'h0);

    // pending counter saturates at 3 outstanding writes to r2
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); issue(1'b1, 2);
      #1; chk("fill_r2", 32'(bus.iss_stall), 32'h0);
    end
    @(negedge clk); idle(); issue(1'b1, 2); set_rd(2, 2, 1'b0);
    #1;
    chk("full_stall", 32'(bus.iss_stall), 32'h1);
    chk("full_busy",  rbusy(2), 32'h1);
    @(negedge clk); wback(2, 16'h0002);
    #1; chk("full_wb_issue", 32'(bus.iss_stall), 32'h0);
    @(negedge clk); bus.wr_en = 1'b0;
    #1; chk("full_again", 32'(bus.iss_stall), 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); wback(2, 16'(k)); set_rd(2, 2, 1'b0);
      #1; chk("drain_busy", rbusy(2), (k < 2) ? 32'h1 : 32'h0);
    end
    @(negedge clk); idle(); set_rd(2, 2, 1'b0);
    #1;
    chk("drain_data", rdata(2), 32'h2);
    chk("err_ok2",    32'(bus.sb_err), 32'h0);

    // write-protected r7
    @(negedge clk); idle(); wback(7, 16'hBEEF); issue(1'b1, 7); set_rd(2, 7, 1'b1);
    #1;
    chk("ro_byp",   rdata(2), 32'h0);
    chk("ro_busy",  rbusy(2), 32'h0);
    chk("ro_stall", 32'(bus.iss_stall), 32'h0);
    @(negedge clk); idle(); issue(1'b0, 0); set_rd(2, 7, 1'b1);
    #1;
    chk("ro_data",   rdata(2), 32'h0);
    chk("ro_busy2",  rbusy(2), 32'h0);
    chk("ro_stall2", 32'(bus.iss_stall), 32'h0);
    chk("ro_err",    32'(bus.sb_err), 32'h0);

    // writeback with nothing pending is flagged and sticky
    @(negedge clk); idle(); wback(5, 16'h5A5A);
    #1; chk("unf_pre", 32'(bus.sb_err), 32'h0);
    @(negedge clk); idle(); set_rd(0, 5, 1'b1);
    #1;
    chk("unf_data", rdata(0), 32'h5A5A);
    chk("unf_err",  32'(bus.sb_err), 32'h1);
    chk("unf_busy", rbusy(0), 32'h0);
    repeat (3) @(negedge clk);
    #1; chk("err_sticky", 32'(bus.sb_err), 32'h1);

    // asynchronous reset with r1 holding two pending writes
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle(); issue(1'b1, 1);
      #1; chk("iss_r1", 32'(bus.iss_stall), 32'h0);
    end
    @(negedge clk); idle(); issue(1'b0, 0); set_rd(0, 1, 1'b1); set_rd(1, 5, 1'b0);
    #1;
    chk("r1_busy",  rbusy(0), 32'h1);
    chk("r1_stall", 32'(bus.iss_stall), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("ar_busy",  rbusy(0), 32'h0);
    chk("ar_stall", 32'(bus.iss_stall), 32'h0);
    chk("ar_err",   32'(bus.sb_err), 32'h0);
    chk("ar_r5",    rdata(1), 32'h0);
    @(negedge clk); idle(); reset = 1'b0;
    @(negedge clk); wback(1, 16'h1111);
    #1; chk("post_err_pre", 32'(bus.sb_err), 32'h0);
    @(negedge clk); idle(); set_rd(0, 1, 1'b0);
    #1;
    chk("post_err",  32'(bus.sb_err), 32'h1);
    chk("post_data", rdata(0), 32'h1111);

    if (sbq.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_leftover: observed %0d required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated write-pending scoreboard, the next-generation replacement for the fixed 8×16, 3-read-port register file of the single-step 16-bit core. It adds configurable width, depth and read-port count, same-cycle writeback bypass, a configurable write-protected register, and per-register pending-write counters. Decode uses these counters to stall on read-after-write hazards instead of relying on a fixed pipeline depth. It sits between the decode stage (issue / reads) and the execute stage (writeback).

## Interface
- DATA_W, 16: register width in bits.
- ADDR_W, 3: address width; depth = 2**ADDR_W.
- NUM_RD, 3: read ports. Port NUM_RD-1 is conventionally the debug port.
- CNT_W, 2: pending-counter width; at most 2**CNT_W-1 writes outstanding per register.
- RO_EN, 1: when 1, register RO_IDX ignores writes and never becomes pending.
- RO_IDX, 7: index of the write-protected register.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W].
- rd_chk  in  NUM_RD  port i takes part in hazard check (0 for debug and immediate-only operands).
- rd_data  out  NUM_RD*DATA_W  read data after bypass.
- rd_busy  out  NUM_RD  port i's register still pending after this cycle's writeback.
- iss_valid  in  1  decode wants to issue an instruction.
- iss_wr  in  1  issuing instruction writes a register.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- iss_stall  out  1  issue refused this cycle.
- wr_en  in  1  writeback valid.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback value.
- sb_err  out  1  sticky flag: writeback arrived with pending count 0.

## Operation
- Storage: 2**ADDR_W × DATA_W. Pending counters: 2**ADDR_W × CNT_W.
- Protected write: wp = wr_en && !(RO_EN && wr_addr==RO_IDX). The array is written only when wp is 1.
- Read, per port: rd_data = wr_data when wp && wr_addr==rd_addr; otherwise array[rd_addr].
- Net count, per register r: eff[r] = cnt[r] − (wp && wr_addr==r && cnt[r]!=0).
- Busy: rd_busy[i] = (eff[rd_addr[i]] != 0).
- Issue check:
  - full = iss_wr && eff[iss_addr]==2**CNT_W−1.
  - iss_stall = iss_valid && (OR over i of rd_chk[i]&&rd_busy[i] || full).
- Issue accept: acc = iss_valid && !iss_stall && iss_wr && !(RO_EN && iss_addr==RO_IDX).
- Counter update at the rising edge: cnt[r] <= eff[r] + (acc && iss_addr==r).
  - Issue and writeback to the same register in one cycle leave the count unchanged.
  - Counters neither wrap nor underflow.
- Error: a writeback (wp) with cnt[wr_addr]==0 updates the data normally, leaves the count at 0, and sets sb_err. sb_err clears only on reset.
- Non-writing instructions (iss_wr=0, e.g. branches) are still subject to the source hazard check.

## Timing
- Reads, bypass, rd_busy and iss_stall are combinational: 0-cycle latency.
- Writes, counter updates and sb_err update on the rising edge of clk.
- Reset (asynchronous, active-high):
  - All registers go to 0, all counters to 0, sb_err to 0.
  - While reset is held: rd_data reflects zeros (or the bypassed wr_data), and iss_stall = 0 because nothing is pending.
  - Reset asserted mid-operation discards all pending state. Writebacks arriving after release with count 0 set sb_err; the pipeline is flushed on the same reset.
- A write to a register is visible on a read in the same cycle via bypass, and from the array on every later cycle.

## Structure
- The shared package holds the core-wide constants: DATA_W, ADDR_W, RO_IDX default, and the debug-port index convention.
- One sub-module, sb_counter: a single CNT_W-bit pending counter.
  - Inputs: inc, dec.
  - Outputs: eff, full, underflow.
  - Instantiated 2**ADDR_W times.
- Data array and bypass muxes live in the top level.

## Test plan
- Reset hold: reset=1, read all 8 addresses → rd_data=0, rd_busy=0, iss_stall=0, sb_err=0.
- Issue r3, then read r3 with rd_chk=1 → iss_stall=1 until wr_en writes r3=0x1234. In that same cycle rd_data=0x1234, rd_busy=0 and iss_stall=0.
- Pending-counter full (CNT_W=2): issue r2 three times, with no writeback in the cycle of the 4th attempt → 4th issue stalls. A writeback in the same cycle as the 4th attempt lets it issue, and the count stays 3.
- Protected register: write r7=0xBEEF and issue to r7 → r7 stays 0 and r7 never shows busy.
- Writeback to r5 with count 0 → r5 is updated and sb_err=1. sb_err stays set until reset.
- Async reset while r1 is pending with count 2 → the counter clears immediately without a clock edge, and rd_busy for r1 drops to 0.
